// File: rtl/csr_counter.sv
// WIDTH-bit hardware event counter (mcycle/minstret style). Software accesses it as
// two 32-bit CSR halves with write/set/clear; a CSR access takes priority over the increment.
module csr_counter #(
    parameter int          WIDTH     = 64,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             inhibit_i,
    input  logic             csr_we_i,
    input  logic [1:0]       csr_op_i,
    input  logic             csr_sel_hi_i,
    input  logic [31:0]      csr_wdata_i,
    output logic [31:0]      rdata_lo_o,
    output logic [31:0]      rdata_hi_o,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o
);

    localparam int HI_W = WIDTH - 32;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             access;
    logic             inc_en;
    logic [31:0]      hi_ext;
    logic [31:0]      lo_new;
    logic [31:0]      hi_new;

    function automatic logic [31:0] apply_op(input logic [1:0]  op,
                                             input logic [31:0] cur,
                                             input logic [31:0] opnd);
        logic [31:0] res;
        case (op)
            OP_WRITE: res = opnd;
            OP_SET:   res = cur | opnd;
            OP_CLEAR: res = cur & ~opnd;
            default:  res = cur;
        endcase
        return res;
    endfunction

    assign access = csr_we_i && (csr_op_i != 2'b00);
    assign inc_en = inc_i && !inhibit_i && !access;

    // High half zero-extended to 32 bits; bits above HI_W are dropped when written back.
    always_comb begin
        hi_ext             = '0;
        hi_ext[HI_W-1:0]   = count_q[WIDTH-1:32];
    end

    assign lo_new = apply_op(csr_op_i, count_q[31:0], csr_wdata_i);
    assign hi_new = apply_op(csr_op_i, hi_ext, csr_wdata_i);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (access) begin
            if (csr_sel_hi_i) begin
                count_d[WIDTH-1:32] = hi_new[HI_W-1:0];
            end else begin
                count_d[31:0] = lo_new;
            end
        end else if (inc_en) begin
            count_d = count_q + WIDTH'(1);
            ovf_d   = (count_q == {WIDTH{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VAL[WIDTH-1:0];
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign rdata_lo_o = count_q[31:0];
    assign rdata_hi_o = hi_ext;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_csr_counter.sv
// Directed bench for csr_counter: a 64-bit instance (RESET_VAL=5) and a 48-bit instance
// driven by the same stimulus, checked against hand-computed values.
module tb_csr_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc_i = 1'b0;
    logic        inhibit_i = 1'b0;
    logic        csr_we_i = 1'b0;
    logic [1:0]  csr_op_i = 2'b00;
    logic        csr_sel_hi_i = 1'b0;
    logic [31:0] csr_wdata_i = '0;

    logic [31:0] lo64, hi64, lo48, hi48;
    logic [63:0] cnt64;
    logic [47:0] cnt48;
    logic        ovf64, ovf48;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    csr_counter #(.WIDTH(64), .RESET_VAL(64'h5)) dut64 (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_i), .inhibit_i(inhibit_i),
        .csr_we_i(csr_we_i), .csr_op_i(csr_op_i), .csr_sel_hi_i(csr_sel_hi_i),
        .csr_wdata_i(csr_wdata_i), .rdata_lo_o(lo64), .rdata_hi_o(hi64),
        .count_o(cnt64), .ovf_o(ovf64)
    );

    csr_counter #(.WIDTH(48), .RESET_VAL(64'h0)) dut48 (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_i), .inhibit_i(inhibit_i),
        .csr_we_i(csr_we_i), .csr_op_i(csr_op_i), .csr_sel_hi_i(csr_sel_hi_i),
        .csr_wdata_i(csr_wdata_i), .rdata_lo_o(lo48), .rdata_hi_o(hi48),
        .count_o(cnt48), .ovf_o(ovf48)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic hi, input logic [31:0] data);
        csr_we_i     = 1'b1;
        csr_op_i     = op;
        csr_sel_hi_i = hi;
        csr_wdata_i  = data;
        step();
        csr_we_i     = 1'b0;
        csr_op_i     = 2'b00;
    endtask

    initial begin
        #12;
        check("reset_count", cnt64, 64'h5);
        check("reset_hi", {32'h0, hi64}, 64'h0);
        check("reset_ovf", {63'h0, ovf64}, 64'h0);
        check("reset_count48", {16'h0, cnt48}, 64'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        inc_i = 1'b1;
        step();
        check("inc_1", cnt64, 64'h6);
        step();
        step();
        check("inc_3", cnt64, 64'h8);
        inc_i = 1'b0;

        // Carry from low into high half
        csr(2'b01, 1'b0, 32'hFFFF_FFFE);
        csr(2'b01, 1'b1, 32'h0);
        check("carry_setup", cnt64, 64'h0000_0000_FFFF_FFFE);
        inc_i = 1'b1;
        step();
        check("carry_lo_ff", {32'h0, lo64}, 64'hFFFF_FFFF);
        step();
        check("carry_lo", {32'h0, lo64}, 64'h0);
        check("carry_hi", {32'h0, hi64}, 64'h1);
        check("carry_no_ovf", {63'h0, ovf64}, 64'h0);
        inc_i = 1'b0;

        // Set/clear on high half, 48-bit truncation
        csr(2'b01, 1'b0, 32'h0);
        csr(2'b01, 1'b1, 32'h0);
        check("zero48", {16'h0, cnt48}, 64'h0);
        csr(2'b10, 1'b1, 32'hFFFF_00F0);
        check("set_hi48", {32'h0, hi48}, 64'h0000_00F0);
        check("set_hi64", {32'h0, hi64}, 64'hFFFF_00F0);
        csr(2'b11, 1'b1, 32'h30);
        check("clr_hi48", {32'h0, hi48}, 64'h0000_00C0);
        check("clr_hi64", {32'h0, hi64}, 64'hFFFF_00C0);
        check("clr_count48", {16'h0, cnt48}, 64'h0000_00C0_0000_0000);

        // Access beats increment
        csr(2'b01, 1'b1, 32'h0);
        csr(2'b01, 1'b0, 32'd100);
        check("prio_setup", cnt64, 64'd100);
        inc_i = 1'b1;
        csr(2'b01, 1'b0, 32'd7);
        check("prio_write", cnt64, 64'd7);
        step();
        check("prio_next_inc", cnt64, 64'd8);
        inhibit_i = 1'b1;
        step();
        check("inhibit_1", cnt64, 64'd8);
        step();
        check("inhibit_2", cnt64, 64'd8);
        csr(2'b01, 1'b0, 32'd9);
        check("inhibit_write", cnt64, 64'd9);
        inhibit_i = 1'b0;
        csr(2'b00, 1'b0, 32'h55);
        check("noop_inc", cnt64, 64'd10);
        csr(2'b01, 1'b0, 32'hFFFF_FFFF);
        csr(2'b01, 1'b1, 32'h2);
        check("unsel_half_holds", cnt64, 64'h0000_0002_FFFF_FFFF);
        inc_i = 1'b0;

        // Overflow
        csr(2'b01, 1'b1, 32'hFFFF_FFFF);
        check("ovf_setup", cnt64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ovf_pre", {63'h0, ovf64}, 64'h0);
        inc_i = 1'b1;
        step();
        inc_i = 1'b0;
        check("ovf_wrap", cnt64, 64'h0);
        check("ovf_pulse", {63'h0, ovf64}, 64'h1);
        step();
        check("ovf_one_cycle", {63'h0, ovf64}, 64'h0);
        csr(2'b01, 1'b0, 32'hFFFF_FFFF);
        csr(2'b01, 1'b1, 32'hFFFF_FFFF);
        csr(2'b11, 1'b0, 32'hFFFF_FFFF);
        csr(2'b01, 1'b1, 32'h0);
        check("write_zero_count", cnt64, 64'h0);
        check("write_zero_no_ovf", {63'h0, ovf64}, 64'h0);
        step();
        check("write_zero_no_ovf2", {63'h0, ovf64}, 64'h0);

        // Asynchronous reset during a write
        csr(2'b01, 1'b0, 32'h1234);
        check("rst_setup", cnt64, 64'h1234);
        csr_we_i     = 1'b1;
        csr_op_i     = 2'b01;
        csr_sel_hi_i = 1'b0;
        csr_wdata_i  = 32'hABCD;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", cnt64, 64'h5);
        step();
        check("rst_write_lost", cnt64, 64'h5);
        csr_we_i = 1'b0;
        csr_op_i = 2'b00;
        rst_n    = 1'b1;
        step();
        check("rst_release", cnt64, 64'h5);
        check("rst_ovf", {63'h0, ovf64}, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
